// File: rtl/scan_bist_ctrl.sv
// Scan-test BIST controller: shifts {a,b} into a CHAIN_LEN-bit multiplier scan chain, captures once,
// then unloads the product and checks it. Define SCAN_BIST_OVERLAP_EN to overlap unload with load.
module scan_bist_ctrl #(
  parameter int unsigned CHAIN_LEN    = 8,
  parameter int unsigned NUM_PATTERNS = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 chain_out,
  output logic                 chain_in,
  output logic                 chain_en,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_cnt,
  output logic [CHAIN_LEN-1:0] first_fail,
  output logic                 first_fail_vld
);

  localparam int unsigned          HalfLen = CHAIN_LEN / 2;
  localparam int unsigned          BitW    = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [BitW-1:0]      LastBit = BitW'(CHAIN_LEN - 1);
  localparam logic [CHAIN_LEN-1:0] LastPat = CHAIN_LEN'(NUM_PATTERNS - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StCapture, StUnload, StDone} state_e;

  state_e               state_q, state_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-2:0] resp_q, resp_d;
  logic [15:0]          err_cnt_q, err_cnt_d;
  logic [CHAIN_LEN-1:0] first_fail_q, first_fail_d;
  logic                 first_fail_vld_q, first_fail_vld_d;
  logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic                 chain_in_q, chain_in_d, chain_en_q, chain_en_d;

  logic [HalfLen-1:0]   op_a, op_b;
  logic [CHAIN_LEN-1:0] expect_prod, resp_full;
  logic [15:0]          err_cnt_inc;
  logic                 mismatch;

  assign op_a        = pat_q[CHAIN_LEN-1:HalfLen];
  assign op_b        = pat_q[HalfLen-1:0];
  assign expect_prod = {{HalfLen{1'b0}}, op_a} * {{HalfLen{1'b0}}, op_b};
  // Response arrives LSB first, so the bit sampled now is the MSB of the word.
  assign resp_full   = {chain_out, resp_q};
  assign mismatch    = (resp_full != expect_prod);
  assign err_cnt_inc = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;

`ifdef SCAN_BIST_OVERLAP_EN
  logic [CHAIN_LEN-1:0] pat_succ;
  assign pat_succ = pat_d + 1'b1;
`endif

  always_comb begin
    state_d          = state_q;
    bit_d            = bit_q;
    pat_d            = pat_q;
    resp_d           = resp_q;
    err_cnt_d        = err_cnt_q;
    first_fail_d     = first_fail_q;
    first_fail_vld_d = first_fail_vld_q;
    busy_d           = busy_q;
    done_d           = done_q;
    pass_d           = pass_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          err_cnt_d        = '0;
          first_fail_d     = '0;
          first_fail_vld_d = 1'b0;
          done_d           = 1'b0;
          pass_d           = 1'b0;
          busy_d           = 1'b1;
          pat_d            = '0;
          bit_d            = '0;
          state_d          = StLoad;
        end
      end
      StLoad: begin
        bit_d = bit_q + 1'b1;
        if (bit_q == LastBit) begin
          bit_d   = '0;
          state_d = StCapture;
        end
      end
      StCapture: begin
        bit_d   = '0;
        state_d = StUnload;
      end
      StUnload: begin
        resp_d = resp_full[CHAIN_LEN-1:1];
        bit_d  = bit_q + 1'b1;
        if (bit_q == LastBit) begin
          bit_d = '0;
          if (mismatch) begin
            err_cnt_d = err_cnt_inc;
            if (!first_fail_vld_q) begin
              first_fail_d     = pat_q;
              first_fail_vld_d = 1'b1;
            end
          end
          if (pat_q == LastPat) begin
            state_d = StDone;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_cnt_d == 16'd0);
          end else begin
            pat_d = pat_q + 1'b1;
`ifdef SCAN_BIST_OVERLAP_EN
            state_d = StCapture;
`else
            state_d = StLoad;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Chain drive is registered, so it is derived from the state being entered.
    chain_en_d = (state_d == StLoad) || (state_d == StUnload);
    chain_in_d = 1'b0;
    if (state_d == StLoad) chain_in_d = pat_d[bit_d];
`ifdef SCAN_BIST_OVERLAP_EN
    if (state_d == StUnload && pat_d != LastPat) chain_in_d = pat_succ[bit_d];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      bit_q            <= '0;
      pat_q            <= '0;
      resp_q           <= '0;
      err_cnt_q        <= '0;
      first_fail_q     <= '0;
      first_fail_vld_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      chain_in_q       <= 1'b0;
      chain_en_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      bit_q            <= bit_d;
      pat_q            <= pat_d;
      resp_q           <= resp_d;
      err_cnt_q        <= err_cnt_d;
      first_fail_q     <= first_fail_d;
      first_fail_vld_q <= first_fail_vld_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      chain_in_q       <= chain_in_d;
      chain_en_q       <= chain_en_d;
    end
  end

  assign chain_in       = chain_in_q;
  assign chain_en       = chain_en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_fail     = first_fail_q;
  assign first_fail_vld = first_fail_vld_q;

endmodule
